// File: rtl/dsp_mac_pipe_pkg.sv
// Shared OPMODE encodings and accumulator limit helpers for the dsp_mac_pipe slice.
package dsp_mac_pipe_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_ACC  = 2'b01,
        OP_ADDC = 2'b10,
        OP_CASC = 2'b11
    } opmode_e;

    localparam int MAX_ACC_W = 128;

    // Callers keep the low acc_w bits: 0111..1 and 1000..0 respectively.
    function automatic logic [MAX_ACC_W-1:0] sat_pos_limit(input int acc_w);
        return (MAX_ACC_W'(1) << (acc_w - 1)) - MAX_ACC_W'(1);
    endfunction

    function automatic logic [MAX_ACC_W-1:0] sat_neg_limit(input int acc_w);
        return ~sat_pos_limit(acc_w);
    endfunction

endpackage

// File: rtl/dsp_mac_pipe_pipe_reg.sv
// Optional pipeline register with clock enable and synchronous active-low clear.
// With EN=0 it degenerates to a wire so stage counts stay parameter-driven.
module pipe_reg #(
    parameter int N  = 1,
    parameter bit EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    generate
        if (EN) begin : g_reg
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    q <= '0;
                end else if (ce) begin
                    q <= d;
                end
            end
        end else begin : g_wire
            logic unused_ctrl;
            assign unused_ctrl = &{1'b0, clk, rst_n, ce};
            assign q = d;
        end
    endgenerate

endmodule

// File: rtl/dsp_mac_pipe.sv
// Signed multiply-accumulate slice: optional input and product stages feeding a
// P register with load/accumulate/add-C/cascade modes and optional saturation.
module dsp_mac_pipe
    import dsp_mac_pipe_pkg::*;
#(
    parameter int DATA_W = 18,
    parameter int ACC_W  = 48,
    parameter int AREG   = 1,
    parameter int MREG   = 1,
    parameter int SAT    = 0
) (
    input  logic                       clk,
    input  logic                       RST_N,
    input  logic                       CE,
    input  logic                       IN_VALID,
    input  logic signed [DATA_W-1:0]   A,
    input  logic signed [DATA_W-1:0]   B,
    input  logic signed [ACC_W-1:0]    C,
    input  logic signed [ACC_W-1:0]    PCIN,
    input  logic [1:0]                 OPMODE,
    output logic signed [2*DATA_W-1:0] M,
    output logic signed [ACC_W-1:0]    P,
    output logic signed [ACC_W-1:0]    PCOUT,
    output logic                       P_VALID,
    output logic                       OVF
);

    localparam int EXT_W = ACC_W + 1 - 2*DATA_W;
    localparam logic signed [ACC_W-1:0] SAT_POS = ACC_W'(sat_pos_limit(ACC_W));
    localparam logic signed [ACC_W-1:0] SAT_NEG = ACC_W'(sat_neg_limit(ACC_W));

    logic signed [DATA_W-1:0]   a_p1, b_p1;
    logic signed [ACC_W-1:0]    c_p1, c_p2;
    logic [1:0]                 op_p1, op_p2;
    logic                       vld_p1, vld_p2;
    logic signed [2*DATA_W-1:0] m_p1, m_p2;
    logic signed [ACC_W:0]      addend_p2, m_ext_p2, sum_p2;
    logic                       ovf_p2;

    function automatic logic signed [ACC_W-1:0] sat_or_wrap(input logic signed [ACC_W:0] s);
        if ((SAT != 0) && (s[ACC_W] != s[ACC_W-1])) begin
            return s[ACC_W] ? SAT_NEG : SAT_POS;
        end
        return s[ACC_W-1:0];
    endfunction

    // ---- p0 -> p1: input stage (A, B, C, OPMODE, valid) ----
    pipe_reg #(.N(DATA_W), .EN(AREG != 0)) u_a_p1 (
        .clk(clk), .rst_n(RST_N), .ce(CE), .d(A), .q(a_p1));
    pipe_reg #(.N(DATA_W), .EN(AREG != 0)) u_b_p1 (
        .clk(clk), .rst_n(RST_N), .ce(CE), .d(B), .q(b_p1));
    pipe_reg #(.N(ACC_W), .EN(AREG != 0)) u_c_p1 (
        .clk(clk), .rst_n(RST_N), .ce(CE), .d(C), .q(c_p1));
    pipe_reg #(.N(2), .EN(AREG != 0)) u_op_p1 (
        .clk(clk), .rst_n(RST_N), .ce(CE), .d(OPMODE), .q(op_p1));
    pipe_reg #(.N(1), .EN(AREG != 0)) u_vld_p1 (
        .clk(clk), .rst_n(RST_N), .ce(CE), .d(IN_VALID), .q(vld_p1));

    assign m_p1 = a_p1 * b_p1;

    // ---- p1 -> p2: product stage, with C/OPMODE/valid kept aligned ----
    pipe_reg #(.N(2*DATA_W), .EN(MREG != 0)) u_m_p2 (
        .clk(clk), .rst_n(RST_N), .ce(CE), .d(m_p1), .q(m_p2));
    pipe_reg #(.N(ACC_W), .EN(MREG != 0)) u_c_p2 (
        .clk(clk), .rst_n(RST_N), .ce(CE), .d(c_p1), .q(c_p2));
    pipe_reg #(.N(2), .EN(MREG != 0)) u_op_p2 (
        .clk(clk), .rst_n(RST_N), .ce(CE), .d(op_p1), .q(op_p2));
    pipe_reg #(.N(1), .EN(MREG != 0)) u_vld_p2 (
        .clk(clk), .rst_n(RST_N), .ce(CE), .d(vld_p1), .q(vld_p2));

    // ---- p2 -> P: one guard bit so overflow shows as disagreeing top bits ----
    always_comb begin
        addend_p2 = '0;
        case (opmode_e'(op_p2))
            OP_ACC:  addend_p2 = {P[ACC_W-1], P};
            OP_ADDC: addend_p2 = {c_p2[ACC_W-1], c_p2};
            OP_CASC: addend_p2 = {PCIN[ACC_W-1], PCIN};
            default: addend_p2 = '0;
        endcase
    end

    assign m_ext_p2 = {{EXT_W{m_p2[2*DATA_W-1]}}, m_p2};
    assign sum_p2   = addend_p2 + m_ext_p2;
    assign ovf_p2   = sum_p2[ACC_W] ^ sum_p2[ACC_W-1];

    always_ff @(posedge clk) begin
        if (!RST_N) begin
            P       <= '0;
            P_VALID <= 1'b0;
            OVF     <= 1'b0;
        end else if (CE) begin
            P_VALID <= vld_p2;
            OVF     <= vld_p2 & ovf_p2;
            if (vld_p2) begin
                P <= sat_or_wrap(sum_p2);
            end
        end
    end

    assign PCOUT = P;
    assign M     = m_p2;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Bench for dsp_mac_pipe: three slices (default, saturating, unregistered) share
// one stimulus stream; expectations come from directed constants and a beat-level model.
module tb_dsp_mac_pipe;

    localparam int DW = 18;
    localparam int AW = 48;
    localparam int NI = 3;
    localparam longint PMAX = (longint'(1) <<< (AW-1)) - 1;
    localparam longint PMIN = -(longint'(1) <<< (AW-1));

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_n, ce, in_valid;
    logic signed [DW-1:0]   a, b;
    logic signed [AW-1:0]   c, pcin;
    logic [1:0]             opmode;
    logic signed [2*DW-1:0] m_o  [NI];
    logic signed [AW-1:0]   p_o  [NI];
    logic signed [AW-1:0]   pc_o [NI];
    logic                   pv_o [NI];
    logic                   ovf_o[NI];

    dsp_mac_pipe #(.DATA_W(DW), .ACC_W(AW), .AREG(1), .MREG(1), .SAT(0)) d_def (
        .clk(clk), .RST_N(rst_n), .CE(ce), .IN_VALID(in_valid), .A(a), .B(b), .C(c),
        .PCIN(pcin), .OPMODE(opmode), .M(m_o[0]), .P(p_o[0]), .PCOUT(pc_o[0]),
        .P_VALID(pv_o[0]), .OVF(ovf_o[0]));
    dsp_mac_pipe #(.DATA_W(DW), .ACC_W(AW), .AREG(1), .MREG(1), .SAT(1)) d_sat (
        .clk(clk), .RST_N(rst_n), .CE(ce), .IN_VALID(in_valid), .A(a), .B(b), .C(c),
        .PCIN(pcin), .OPMODE(opmode), .M(m_o[1]), .P(p_o[1]), .PCOUT(pc_o[1]),
        .P_VALID(pv_o[1]), .OVF(ovf_o[1]));
    dsp_mac_pipe #(.DATA_W(DW), .ACC_W(AW), .AREG(0), .MREG(0), .SAT(0)) d_fast (
        .clk(clk), .RST_N(rst_n), .CE(ce), .IN_VALID(in_valid), .A(a), .B(b), .C(c),
        .PCIN(pcin), .OPMODE(opmode), .M(m_o[2]), .P(p_o[2]), .PCOUT(pc_o[2]),
        .P_VALID(pv_o[2]), .OVF(ovf_o[2]));

    // Beat-level reference: each accepted beat lands on P a fixed number of
    // enabled edges later; a reset discards everything not yet landed.
    typedef struct {
        longint     a;
        longint     b;
        longint     c;
        logic [1:0] op;
        int         issue;
    } beat_t;

    beat_t  beats[$];
    int     rd   [NI];
    int     lat  [NI] = '{3, 3, 1};
    bit     satm [NI] = '{1'b0, 1'b1, 1'b0};
    longint exp_p[NI];
    bit     exp_v[NI];
    bit     exp_o[NI];
    int     ecnt;
    int     n_checks;
    int     n_fail;

    function automatic void model_update(input int i, input beat_t bt, input longint pc);
        longint base, s;
        logic [63:0] sv;
        logic signed [AW-1:0] w;
        case (bt.op)
            2'b00:   base = 0;
            2'b01:   base = exp_p[i];
            2'b10:   base = bt.c;
            default: base = pc;
        endcase
        s = base + bt.a * bt.b;
        exp_o[i] = (s > PMAX) || (s < PMIN);
        if (exp_o[i] && satm[i]) begin
            exp_p[i] = (s > PMAX) ? PMAX : PMIN;
        end else begin
            sv = s;
            w = sv[AW-1:0];
            exp_p[i] = w;
        end
        exp_v[i] = 1'b1;
    endfunction

    task automatic tick(input logic r, input logic e, input logic v, input longint av,
                        input longint bv, input longint cv, input logic [1:0] op,
                        input longint pc);
        beat_t bt;
        rst_n = r; ce = e; in_valid = v; opmode = op;
        a = DW'(av); b = DW'(bv); c = AW'(cv); pcin = AW'(pc);
        @(posedge clk);
        if (!r) begin
            for (int i = 0; i < NI; i++) begin
                rd[i] = beats.size(); exp_p[i] = 0; exp_v[i] = 1'b0; exp_o[i] = 1'b0;
            end
        end else if (e) begin
            ecnt++;
            if (v) begin
                bt.a = av; bt.b = bv; bt.c = cv; bt.op = op; bt.issue = ecnt;
                beats.push_back(bt);
            end
            for (int i = 0; i < NI; i++) begin
                exp_v[i] = 1'b0; exp_o[i] = 1'b0;
                if (rd[i] < beats.size() && beats[rd[i]].issue + lat[i] - 1 == ecnt) begin
                    model_update(i, beats[rd[i]], pc);
                    rd[i]++;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        int first[NI];
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b1, 1'b1, 5, 5, 0, 2'b01, 0);
            for (int i = 0; i < NI; i++) begin
                n_checks++;
                if (p_o[i] !== '0 || pv_o[i] !== 1'b0 || ovf_o[i] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_hold inst%0d: P=%0d P_VALID=%b OVF=%b, required 0/0/0",
                             i, p_o[i], pv_o[i], ovf_o[i]);
                end
            end
        end
        for (int i = 0; i < NI; i++) first[i] = -1;
        for (int k = 1; k <= 5; k++) begin
            if (k == 1) tick(1'b1, 1'b1, 1'b1, 3, 3, 0, 2'b00, 0);
            else        tick(1'b1, 1'b1, 1'b0, 0, 0, 0, 2'b00, 0);
            for (int i = 0; i < NI; i++) if (pv_o[i] === 1'b1 && first[i] < 0) first[i] = k;
        end
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (first[i] != lat[i]) begin
                n_fail++;
                $display("FAIL reset_release_latency inst%0d: first P_VALID at cycle %0d, required %0d",
                         i, first[i], lat[i]);
            end
        end
    endtask

    task automatic test_load();
        for (int k = 1; k <= 4; k++) begin
            if (k == 1) tick(1'b1, 1'b1, 1'b1, 3, -4, 0, 2'b00, 0);
            else        tick(1'b1, 1'b1, 1'b0, 0, 0, 0, 2'b00, 0);
            if (k == 1) begin
                n_checks++;
                if (longint'(p_o[2]) !== -12 || pv_o[2] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL load_fast: P=%0d P_VALID=%b, required -12/1", p_o[2], pv_o[2]);
                end
            end
            if (k == 2) begin
                n_checks++;
                if (longint'(m_o[0]) !== -12 || pv_o[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL load_m_stage: M=%0d P_VALID=%b, required -12/0", m_o[0], pv_o[0]);
                end
            end
            if (k == 3) begin
                n_checks++;
                if (longint'(p_o[0]) !== -12 || pv_o[0] !== 1'b1 || ovf_o[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL load_p: P=%0d P_VALID=%b OVF=%b, required -12/1/0",
                             p_o[0], pv_o[0], ovf_o[0]);
                end
            end
            if (k == 4) begin
                n_checks++;
                if (pv_o[0] !== 1'b0 || longint'(p_o[0]) !== -12) begin
                    n_fail++;
                    $display("FAIL load_single_pulse: P=%0d P_VALID=%b, required -12/0", p_o[0], pv_o[0]);
                end
            end
        end
    endtask

    task automatic test_accumulate();
        int got[NI] = '{0, 0, 0};
        for (int k = 1; k <= 9; k++) begin
            if (k == 1)      tick(1'b1, 1'b1, 1'b1, 0, 9, 0, 2'b00, 0);
            else if (k <= 5) tick(1'b1, 1'b1, 1'b1, 2, 5, 0, 2'b01, 0);
            else             tick(1'b1, 1'b1, 1'b0, 0, 0, 0, 2'b00, 0);
            for (int i = 0; i < NI; i++) begin
                if (pv_o[i] === 1'b1) begin
                    n_checks++;
                    if (longint'(p_o[i]) !== longint'(10 * got[i]) || k != lat[i] + got[i]) begin
                        n_fail++;
                        $display("FAIL accumulate inst%0d: P=%0d at cycle %0d, required %0d at cycle %0d",
                                 i, p_o[i], k, 10 * got[i], lat[i] + got[i]);
                    end
                    got[i]++;
                end
            end
        end
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (got[i] != 5) begin
                n_fail++;
                $display("FAIL accumulate_count inst%0d: %0d results, required 5", i, got[i]);
            end
        end
    endtask

    task automatic test_add_modes();
        longint want[2] = '{93, -34};
        int got[NI] = '{0, 0, 0};
        for (int k = 1; k <= 5; k++) begin
            if (k == 1)      tick(1'b1, 1'b1, 1'b1, -1, 7, 100, 2'b10, -50);
            else if (k == 2) tick(1'b1, 1'b1, 1'b1, 4, 4, 0, 2'b11, -50);
            else             tick(1'b1, 1'b1, 1'b0, 0, 0, 0, 2'b00, -50);
            for (int i = 0; i < NI; i++) begin
                if (pv_o[i] === 1'b1 && got[i] < 2) begin
                    n_checks++;
                    if (longint'(p_o[i]) !== want[got[i]] || longint'(pc_o[i]) !== want[got[i]]) begin
                        n_fail++;
                        $display("FAIL add_mode inst%0d: P=%0d PCOUT=%0d, required %0d",
                                 i, p_o[i], pc_o[i], want[got[i]]);
                    end
                    got[i]++;
                end
            end
        end
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (got[i] != 2) begin
                n_fail++;
                $display("FAIL add_mode_count inst%0d: %0d results, required 2", i, got[i]);
            end
        end
    endtask

    task automatic test_overflow();
        longint want[NI][3];
        bit     wovf[3] = '{1'b0, 1'b1, 1'b0};
        int     got[NI] = '{0, 0, 0};
        for (int i = 0; i < NI; i++) begin
            want[i][0] = PMAX - 5;
            want[i][1] = satm[i] ? PMAX : PMIN + 6;
            want[i][2] = satm[i] ? PMAX - 1 : PMIN + 5;
        end
        for (int k = 1; k <= 6; k++) begin
            if (k == 1)      tick(1'b1, 1'b1, 1'b1, 0, 0, PMAX - 5, 2'b10, 0);
            else if (k == 2) tick(1'b1, 1'b1, 1'b1, 3, 4, 0, 2'b01, 0);
            else if (k == 3) tick(1'b1, 1'b1, 1'b1, -1, 1, 0, 2'b01, 0);
            else             tick(1'b1, 1'b1, 1'b0, 0, 0, 0, 2'b00, 0);
            for (int i = 0; i < NI; i++) begin
                if (pv_o[i] === 1'b1 && got[i] < 3) begin
                    n_checks++;
                    if (longint'(p_o[i]) !== want[i][got[i]] || ovf_o[i] !== wovf[got[i]]) begin
                        n_fail++;
                        $display("FAIL overflow inst%0d step%0d: P=%0d OVF=%b, required P=%0d OVF=%b",
                                 i, got[i], p_o[i], ovf_o[i], want[i][got[i]], wovf[got[i]]);
                    end
                    got[i]++;
                end
            end
        end
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (got[i] != 3) begin
                n_fail++;
                $display("FAIL overflow_count inst%0d: %0d results, required 3", i, got[i]);
            end
        end
    endtask

    task automatic test_stall_reset();
        int got[NI] = '{0, 0, 0};
        for (int k = 1; k <= 13; k++) begin
            if (k <= 3)      tick(1'b1, 1'b1, 1'b1, k, 10, 0, 2'b00, 0);
            else if (k <= 8) tick(1'b1, 1'b0, 1'b1, 7, 7, 0, 2'b01, 0);
            else             tick(1'b1, 1'b1, 1'b0, 0, 0, 0, 2'b00, 0);
            for (int i = 0; i < NI; i++) begin
                n_checks++;
                if (longint'(p_o[i]) !== exp_p[i] || pv_o[i] !== exp_v[i] || ovf_o[i] !== exp_o[i]) begin
                    n_fail++;
                    $display("FAIL stall_model inst%0d cyc%0d: P=%0d V=%b O=%b, required P=%0d V=%b O=%b",
                             i, k, p_o[i], pv_o[i], ovf_o[i], exp_p[i], exp_v[i], exp_o[i]);
                end
                if ((k <= 3 || k >= 9) && pv_o[i] === 1'b1) begin
                    n_checks++;
                    if (longint'(p_o[i]) !== longint'(10 * (got[i] + 1))) begin
                        n_fail++;
                        $display("FAIL stall_order inst%0d: P=%0d, required %0d", i, p_o[i], 10 * (got[i] + 1));
                    end
                    got[i]++;
                end
            end
        end
        for (int k = 1; k <= 7; k++) begin
            if (k <= 2)      tick(1'b1, 1'b1, 1'b1, 5, 5, 0, 2'b00, 0);
            else if (k == 3) tick(1'b0, 1'b1, 1'b0, 0, 0, 0, 2'b00, 0);
            else             tick(1'b1, 1'b1, 1'b0, 0, 0, 0, 2'b00, 0);
            if (k >= 3) begin
                for (int i = 0; i < NI; i++) begin
                    n_checks++;
                    if (pv_o[i] !== 1'b0 || p_o[i] !== '0) begin
                        n_fail++;
                        $display("FAIL reset_flush inst%0d cyc%0d: P=%0d P_VALID=%b, required 0/0",
                                 i, k, p_o[i], pv_o[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        logic signed [DW-1:0] ra, rb;
        logic signed [AW-1:0] rc, rp;
        for (int k = 0; k < 400; k++) begin
            ra = DW'($urandom); rb = DW'($urandom);
            rc = AW'({$urandom, $urandom}); rp = AW'({$urandom, $urandom});
            if (k < 390)
                tick(1'b1, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), longint'(ra),
                     longint'(rb), longint'(rc), 2'($urandom_range(0, 3)), longint'(rp));
            else
                tick(1'b1, 1'b1, 1'b0, 0, 0, 0, 2'b00, longint'(rp));
            for (int i = 0; i < NI; i++) begin
                n_checks++;
                if (longint'(p_o[i]) !== exp_p[i] || longint'(pc_o[i]) !== exp_p[i] ||
                    pv_o[i] !== exp_v[i] || ovf_o[i] !== exp_o[i]) begin
                    n_fail++;
                    $display("FAIL random inst%0d cyc%0d: P=%0d PCOUT=%0d V=%b O=%b, required P=%0d V=%b O=%b",
                             i, k, p_o[i], pc_o[i], pv_o[i], ovf_o[i], exp_p[i], exp_v[i], exp_o[i]);
                end
            end
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; ecnt = 0;
        for (int i = 0; i < NI; i++) begin
            rd[i] = 0; exp_p[i] = 0; exp_v[i] = 1'b0; exp_o[i] = 1'b0;
        end
        test_reset();
        test_load();
        test_accumulate();
        test_add_modes();
        test_overflow();
        test_stall_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
